add_seq_ctrl: RTL

Multi-word adder/subtractor controller that computes a 4*NIBBLES-bit sum on one shared add4 instance, one nibble per clock, least significant nibble first. It owns the carry chain between nibbles, sequences the operand slices and collects the result. A start/busy/done handshake makes it a drop-in arithmetic unit for wider datapaths without replicating add4.

---
 rtl/add_seq_ctrl_pkg.sv | 19 +
 rtl/add_seq_ctrl_add4.sv | 21 ++
 rtl/add_seq_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor controller.
//   - NIBBLE_W   : width of one datapath slice (the shared add4)
//   - state_t    : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   - idx_width(): width of the slice index, never less than one bit
package add_seq_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_add4.sv
// 4-bit ripple adder used as the single shared datapath slice.
// Ports:
//   a, b : 4-bit operand slices
//   ci   : carry into bit 0
//   s    : 4-bit sum
//   co   : carry out of bit 3
module add4
    import add_seq_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-word adder/subtractor that reuses one add4, one nibble per clock,
// least significant nibble first.
//
// Handshake: start is only looked at in IDLE or DONE; when seen there the
// operands are latched and busy rises on the next cycle for exactly NIBBLES
// cycles, followed by a single-cycle done pulse with r/co/ov freshly loaded.
// start while busy is dropped, not queued.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   start      : operation request
//   sub        : 0 = a+b+ci, 1 = a-b (ci ignored)
//   a, b, ci   : operands, latched on an accepted start
//   busy, done : status (registered)
//   r, co, ov  : result, carry out of MSB (1 = no borrow for sub), signed overflow
//   dbg_state  : current controller state
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sub,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                     ci,
    output logic                     busy,
    output logic                     done,
    output logic [NIBBLE_W*NIBBLES-1:0] r,
    output logic                     co,
    output logic                     ov,
    output logic [1:0]               dbg_state
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q,  state_d;
    logic [W-1:0]     a_q,      a_d;
    logic [W-1:0]     b_q,      b_d;      // already inverted for subtract
    logic             carry_q,  carry_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     r_q,      r_d;
    logic             co_q,     co_d;
    logic             ov_q,     ov_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    logic [NIBBLE_W-1:0] slice_a;
    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_co;
    logic [W-1:0]        shadow_upd;

    assign slice_a = a_q[idx_q * NIBBLE_W +: NIBBLE_W];
    assign slice_b = b_q[idx_q * NIBBLE_W +: NIBBLE_W];

    add4 u_add4 (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        r_d      = r_q;
        co_d     = co_q;
        ov_d     = ov_q;

        // Shadow with the current slice merged in; on the last slice this is
        // the complete sum, so the result can be loaded in the same edge.
        shadow_upd = shadow_q;
        shadow_upd[idx_q * NIBBLE_W +: NIBBLE_W] = slice_s;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b ^ {W{sub}};
                    carry_d = sub ? 1'b1 : ci;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                shadow_d = shadow_upd;
                carry_d  = slice_co;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    r_d     = shadow_upd;
                    co_d    = slice_co;
                    // Operands of equal sign producing a result of the other sign.
                    ov_d    = (a_q[W-1] == b_q[W-1]) && (shadow_upd[W-1] != a_q[W-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            shadow_q <= '0;
            r_q      <= '0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            r_q      <= r_d;
            co_q     <= co_d;
            ov_q     <= ov_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign r         = r_q;
    assign co        = co_q;
    assign ov        = ov_q;
    assign dbg_state = state_q;

endmodule
